// File: rtl/mem_access_unit.sv
// Memory access stage between the multi-cycle RV32I controller and a
// shared instruction/data bus with variable wait states.
module mem_access_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TIMEOUT = 16,
    parameter logic [DATA_W-1:0] RESET_INSTR = 'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic              ir_load,
    input  logic [ADDR_W-1:0] mem_adr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              fault_clr,
    output logic              mem_busy,
    output logic              mem_done,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] old_pc,
    output logic [DATA_W-1:0] data_q,
    output logic              mem_fault,
    output logic [1:0]        fault_code,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] FAULT = 3'd4;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam bit TO_EN = (TIMEOUT != 0);

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_ALIGN = 2'b01;
    localparam logic [1:0] FC_TIME  = 2'b10;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              fetch_q;
    logic [ADDR_W-1:0] pc_q;

    logic take;
    logic misaligned;
    logic in_flight;
    logic timeout_hit;
    logic accept;
    logic expire;

    assign take       = (state == IDLE) && mem_req;
    assign misaligned = (mem_adr[1:0] != 2'b00);
    assign in_flight  = (state == REQ) || (state == WAIT);
    assign timeout_hit = TO_EN && (cnt == CNT_LAST);

    assign mem_busy  = in_flight;
    assign mem_done  = (state == DONE);
    assign mem_fault = (state == FAULT);
    assign bus_req   = (state == REQ);

    // A response in the last allowed cycle is taken before the timeout.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        expire    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req)
                    state_nxt = misaligned ? FAULT : REQ;
            end
            REQ: begin
                if (bus_gnt && bus_rvalid) begin
                    accept    = 1'b1;
                    state_nxt = DONE;
                end else if (timeout_hit) begin
                    expire    = 1'b1;
                    state_nxt = FAULT;
                end else if (bus_gnt) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus_rvalid) begin
                    accept    = 1'b1;
                    state_nxt = DONE;
                end else if (timeout_hit) begin
                    expire    = 1'b1;
                    state_nxt = FAULT;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            FAULT: begin
                if (fault_clr)
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (take) begin
            cnt <= '0;
        end else if (in_flight) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Request fields stay latched until the next accepted request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_we    <= 1'b0;
            fetch_q   <= 1'b0;
            pc_q      <= '0;
        end else if (take) begin
            bus_addr  <= mem_adr;
            bus_wdata <= mem_wdata;
            bus_we    <= mem_we;
            fetch_q   <= ir_load & ~mem_we;
            pc_q      <= pc_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fault_code <= FC_NONE;
        end else if (take && misaligned) begin
            fault_code <= FC_ALIGN;
        end else if (expire) begin
            fault_code <= FC_TIME;
        end else if ((state == FAULT) && fault_clr) begin
            fault_code <= FC_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            instr  <= RESET_INSTR;
            old_pc <= '0;
            data_q <= '0;
        end else if (accept && !bus_we) begin
            if (fetch_q) begin
                instr  <= bus_rdata;
                old_pc <= pc_q;
            end else begin
                data_q <= bus_rdata;
            end
        end
    end

endmodule
